imem_dmem_port_arbiter: RTL and testbench

//  Shares one single-port memory between the instruction-fetch stage (PC/fetch) and the
//  MEM stage (loads/stores). Sequences each access as a held req/ready transaction.

---
 rtl/imem_dmem_port_arbiter_pkg.sv | 18 +
 rtl/imem_dmem_port_arbiter_if.sv | 58 +++++
 rtl/imem_dmem_port_arbiter_rr_arb2.sv | 44 ++++
 rtl/imem_dmem_port_arbiter.sv | 164 ++++++++++++++++
 tb/tb_imem_dmem_port_arbiter.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/imem_dmem_port_arbiter_pkg.sv
// Shared constants for the instruction/data memory port arbiter: word width,
// arbiter state encodings and round-robin grant identifiers.
package imem_dmem_port_arbiter_pkg;

    localparam int WORD_WIDTH = 32;
    localparam logic [WORD_WIDTH-1:0] ZERO_WORD = '0;

    // Arbiter state register encoding (kept as plain constants for legacy tools).
    typedef logic [1:0] arb_state_t;
    localparam arb_state_t ARB_IDLE   = 2'd0;
    localparam arb_state_t ARB_F_BUSY = 2'd1;
    localparam arb_state_t ARB_D_BUSY = 2'd2;

    // Identity of the requester served most recently.
    localparam logic GRANT_FETCH = 1'b0;
    localparam logic GRANT_DATA  = 1'b1;

endpackage

// File: rtl/imem_dmem_port_arbiter_if.sv
// Bundle of the fetch port, data port and single-port memory bus that meet at
// the arbiter. The slave modport is the arbiter's view; master is the
// surrounding core + memory.
interface imem_dmem_port_arbiter_if
    import imem_dmem_port_arbiter_pkg::*;
#(
    parameter int W = WORD_WIDTH
);
    // Pipeline control
    logic             flush;
    // Fetch port
    logic             if_req;
    logic [W-1:0]     if_addr;
    logic [W-1:0]     if_rdata;
    logic             if_valid;
    logic             if_stall;
    // Data port
    logic             d_req;
    logic             d_we;
    logic [W/8-1:0]   d_be;
    logic [W-1:0]     d_addr;
    logic [W-1:0]     d_wdata;
    logic [W-1:0]     d_rdata;
    logic             d_valid;
    logic             d_stall;
    // Memory side
    logic             mem_req;
    logic             mem_we;
    logic [W/8-1:0]   mem_be;
    logic [W-1:0]     mem_addr;
    logic [W-1:0]     mem_wdata;
    logic [W-1:0]     mem_rdata;
    logic             mem_ready;
    logic             bus_err;

    modport slave (
        input  flush,
        input  if_req, if_addr,
        output if_rdata, if_valid, if_stall,
        input  d_req, d_we, d_be, d_addr, d_wdata,
        output d_rdata, d_valid, d_stall,
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready,
        output bus_err
    );

    modport master (
        output flush,
        output if_req, if_addr,
        input  if_rdata, if_valid, if_stall,
        output d_req, d_we, d_be, d_addr, d_wdata,
        input  d_rdata, d_valid, d_stall,
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_rdata, mem_ready,
        input  bus_err
    );

endinterface

// File: rtl/imem_dmem_port_arbiter_rr_arb2.sv
// Two-requester round-robin picker. The grant is combinational; the
// last-served register moves only when the owner accepts the grant.
module imem_dmem_port_arbiter_rr_arb2
    import imem_dmem_port_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_req_fetch,
    input  logic i_req_data,
    input  logic i_accept,
    output logic o_grant_fetch,
    output logic o_grant_data,
    output logic o_any
);

    logic r_last_grant;
    logic w_pick_data;

    // Pick the winner: a lone requester wins, contention goes to whoever was not served last.
    always_comb begin
        // NOTE: default assignment first so no path leaves w_pick_data unassigned (no latch).
        w_pick_data = 1'b0;
        if (i_req_data && !i_req_fetch) begin
            w_pick_data = 1'b1;
        end else if (i_req_data && i_req_fetch) begin
            w_pick_data = (r_last_grant == GRANT_FETCH);
        end
    end

    assign o_grant_data  = w_pick_data;
    assign o_grant_fetch = i_req_fetch && !w_pick_data;
    assign o_any         = i_req_fetch || i_req_data;

    // Remember which requester was served when a grant is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            r_last_grant <= GRANT_FETCH;
        end else if (i_accept && o_any) begin
            r_last_grant <= w_pick_data ? GRANT_DATA : GRANT_FETCH;
        end
    end

endmodule

// File: rtl/imem_dmem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and the MEM stage.
// Each access is a held req/ready transaction; the next grant can launch in
// the completion edge of the previous one. Fetches in flight at a flush are
// completed on the bus but not delivered. A stuck memory is abandoned after
// TIMEOUT busy cycles and flagged in a sticky bus_err.
module imem_dmem_port_arbiter
    import imem_dmem_port_arbiter_pkg::*;
#(
    parameter int W       = WORD_WIDTH,
    parameter int TIMEOUT = 64
)(
    input logic                     clk,
    input logic                     rst,
    imem_dmem_port_arbiter_if.slave bus
);

    localparam int BW = W / 8;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    arb_state_t    r_state;
    logic          r_mem_req;
    logic          r_mem_we;
    logic [BW-1:0] r_mem_be;
    logic [W-1:0]  r_mem_addr;
    logic [W-1:0]  r_mem_wdata;
    logic [TW-1:0] r_timer;
    logic          r_drop;
    logic          r_bus_err;
    logic          r_if_valid;
    logic          r_d_valid;
    logic [W-1:0]  r_if_rdata;
    logic [W-1:0]  r_d_rdata;

    logic          w_f_busy;
    logic          w_d_busy;
    logic          w_busy;
    logic          w_done;
    logic          w_timeout;
    logic          w_finish;
    logic          w_slot;
    logic          w_f_elig;
    logic          w_d_elig;
    logic          w_grant_f;
    logic          w_grant_d;
    logic          w_any;
    logic          w_accept;
    logic          w_drop_now;
    logic [W-1:0]  w_ret_data;

    assign w_f_busy  = (r_state == ARB_F_BUSY);
    assign w_d_busy  = (r_state == ARB_D_BUSY);
    assign w_busy    = w_f_busy || w_d_busy;
    assign w_done    = w_busy && bus.mem_ready;
    assign w_timeout = w_busy && !bus.mem_ready && (r_timer == TW'(TIMEOUT - 1));
    assign w_finish  = w_done || w_timeout;

    // A new grant may launch from IDLE or in the edge that completes an access.
    assign w_slot    = (r_state == ARB_IDLE) || w_done;

    // The owner of the current access, and a requester in its valid cycle, still
    // hold their old request; neither may be granted again until it has moved on.
    assign w_f_elig  = bus.if_req && !r_if_valid && !w_f_busy;
    assign w_d_elig  = bus.d_req  && !r_d_valid  && !w_d_busy;
    assign w_accept  = w_slot && w_any;

    // A flush arriving in the completion cycle still suppresses that delivery.
    assign w_drop_now = r_drop || bus.flush;
    assign w_ret_data = w_done ? bus.mem_rdata : ZERO_WORD[W-1:0];

    imem_dmem_port_arbiter_rr_arb2 u_rr_arb2 (
        .clk           (clk),
        .rst           (rst),
        .i_req_fetch   (w_f_elig),
        .i_req_data    (w_d_elig),
        .i_accept      (w_slot),
        .o_grant_fetch (w_grant_f),
        .o_grant_data  (w_grant_d),
        .o_any         (w_any)
    );

    // Launch, hold and retire the memory command; count stalled busy cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ARB_IDLE;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_be    <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_timer     <= '0;
        end else if (w_accept) begin
            r_mem_req <= 1'b1;
            r_timer   <= '0;
            if (w_grant_d) begin
                r_state     <= ARB_D_BUSY;
                r_mem_we    <= bus.d_we;
                r_mem_be    <= bus.d_we ? bus.d_be : {BW{1'b1}};
                r_mem_addr  <= bus.d_addr;
                r_mem_wdata <= bus.d_wdata;
            end else begin
                r_state     <= ARB_F_BUSY;
                r_mem_we    <= 1'b0;
                r_mem_be    <= {BW{1'b1}};
                r_mem_addr  <= bus.if_addr;
                r_mem_wdata <= '0;
            end
        end else if (w_finish) begin
            r_state   <= ARB_IDLE;
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            r_timer   <= '0;
        end else if (w_busy) begin
            r_timer <= r_timer + TW'(1);
        end
    end

    // Capture returned data, pulse the requester's valid and track drop/error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_if_valid <= 1'b0;
            r_d_valid  <= 1'b0;
            r_if_rdata <= '0;
            r_d_rdata  <= '0;
            r_drop     <= 1'b0;
            r_bus_err  <= 1'b0;
        end else begin
            r_if_valid <= 1'b0;
            r_d_valid  <= 1'b0;
            if (w_finish) begin
                if (w_f_busy) begin
                    if (!w_drop_now) begin
                        r_if_valid <= 1'b1;
                        r_if_rdata <= w_ret_data;
                    end
                    r_drop <= 1'b0;
                end else begin
                    r_d_valid <= 1'b1;
                    if (!r_mem_we) begin
                        r_d_rdata <= w_ret_data;
                    end
                end
            end else if (w_f_busy && bus.flush) begin
                r_drop <= 1'b1;
            end
            if (w_timeout) begin
                r_bus_err <= 1'b1;
            end
        end
    end

    assign bus.mem_req   = r_mem_req;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_be    = r_mem_be;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.if_rdata  = r_if_rdata;
    assign bus.if_valid  = r_if_valid;
    assign bus.d_rdata   = r_d_rdata;
    assign bus.d_valid   = r_d_valid;
    assign bus.bus_err   = r_bus_err;
    assign bus.if_stall  = bus.if_req && !r_if_valid;
    assign bus.d_stall   = bus.d_req && !r_d_valid;

endmodule

// File: tb/tb_imem_dmem_port_arbiter.sv
// Directed bench for imem_dmem_port_arbiter: a table of single accesses with
// hand-computed results, then hand-written sequences for flush, timeout,
// reset mid-access and fetch/data contention.
module tb_imem_dmem_port_arbiter;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    imem_dmem_port_arbiter_if #(.W(32)) bus ();

    imem_dmem_port_arbiter #(.W(32), .TIMEOUT(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          is_data;
        bit          we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mem_rdata;
        int          lat;        // mem_req cycles with mem_ready=0 before the ready cycle
        logic [3:0]  exp_be;
        logic [31:0] exp_rdata;  // requester rdata expected in the valid cycle
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int waits;
        bit first;
        bit got;
        bit stall_ok;
        waits = 0; first = 1'b1; got = 1'b0; stall_ok = 1'b1;
        if (v.is_data) begin
            bus.d_req = 1'b1; bus.d_we = v.we; bus.d_be = v.be;
            bus.d_addr = v.addr; bus.d_wdata = v.wdata;
        end else begin
            bus.if_req = 1'b1; bus.if_addr = v.addr;
        end
        for (int c = 0; c < 40 && !got; c++) begin
            step();
            bus.mem_ready = 1'b0;
            bus.mem_rdata = '0;
            if (v.is_data ? bus.d_valid : bus.if_valid) begin
                got = 1'b1;
                check($sformatf("v%0d rdata", idx), v.is_data ? bus.d_rdata : bus.if_rdata, v.exp_rdata);
                check($sformatf("v%0d stall in valid cycle", idx), v.is_data ? bus.d_stall : bus.if_stall, 1'b0);
                check($sformatf("v%0d mem_req idle after", idx), bus.mem_req, 1'b0);
            end else begin
                if ((v.is_data ? bus.d_stall : bus.if_stall) !== 1'b1) stall_ok = 1'b0;
                if (bus.mem_req) begin
                    if (first) begin
                        first = 1'b0;
                        check($sformatf("v%0d mem_addr", idx), bus.mem_addr, v.addr);
                        check($sformatf("v%0d mem_we", idx), bus.mem_we, v.is_data ? v.we : 1'b0);
                        check($sformatf("v%0d mem_be", idx), bus.mem_be, v.exp_be);
                        if (v.is_data && v.we)
                            check($sformatf("v%0d mem_wdata", idx), bus.mem_wdata, v.wdata);
                    end
                    if (waits == v.lat) begin
                        bus.mem_ready = 1'b1;
                        bus.mem_rdata = v.mem_rdata;
                    end
                    waits++;
                end
            end
        end
        check($sformatf("v%0d valid seen", idx), got, 1'b1);
        check($sformatf("v%0d stall held", idx), stall_ok, 1'b1);
        bus.if_req = 1'b0;
        bus.d_req  = 1'b0;
        bus.d_we   = 1'b0;
        step();
        check($sformatf("v%0d valid one cycle", idx), v.is_data ? bus.d_valid : bus.if_valid, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.flush = 1'b0; bus.if_req = 1'b0; bus.if_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_be = '0; bus.d_addr = '0; bus.d_wdata = '0;
        bus.mem_rdata = '0; bus.mem_ready = 1'b0;

        vecs[0] = '{1'b0, 1'b0, 4'h0,    32'h0000_0000, 32'h0,         32'h2408_0001, 2, 4'hF,    32'h2408_0001};
        vecs[1] = '{1'b1, 1'b0, 4'h0,    32'h0000_0200, 32'h0,         32'h1234_5678, 0, 4'hF,    32'h1234_5678};
        vecs[2] = '{1'b1, 1'b1, 4'b0011, 32'h0000_0100, 32'hDEAD_BEEF, 32'hAAAA_AAAA, 1, 4'b0011, 32'h1234_5678};
        vecs[3] = '{1'b0, 1'b0, 4'h0,    32'h0000_0004, 32'h0,         32'hFFFF_FFFF, 0, 4'hF,    32'hFFFF_FFFF};
        vecs[4] = '{1'b1, 1'b0, 4'h0,    32'h0000_0204, 32'h0,         32'h1357_9BDF, 3, 4'hF,    32'h1357_9BDF};
        vecs[5] = '{1'b1, 1'b1, 4'b1100, 32'h0000_0104, 32'h0F0F_0F0F, 32'h5A5A_5A5A, 0, 4'b1100, 32'h1357_9BDF};

        // Reset state
        repeat (3) step();
        check("reset mem_req", bus.mem_req, 1'b0);
        check("reset mem_we", bus.mem_we, 1'b0);
        check("reset mem_addr", bus.mem_addr, 32'h0);
        check("reset if_valid", bus.if_valid, 1'b0);
        check("reset d_valid", bus.d_valid, 1'b0);
        check("reset if_rdata", bus.if_rdata, 32'h0);
        check("reset d_rdata", bus.d_rdata, 32'h0);
        check("reset bus_err", bus.bus_err, 1'b0);
        rst = 1'b0;
        step();

        // Single accesses from the table
        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // Flush during a fetch of 0x40, redirect to 0x80
        bus.if_req = 1'b1; bus.if_addr = 32'h40;
        step();
        check("flush first mem_req", bus.mem_req, 1'b1);
        check("flush first mem_addr", bus.mem_addr, 32'h40);
        bus.flush = 1'b1; bus.if_addr = 32'h80;
        step();
        bus.flush = 1'b0;
        check("flush addr held", bus.mem_addr, 32'h40);
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'hBAD0_0040;
        step();
        bus.mem_ready = 1'b0; bus.mem_rdata = '0;
        check("flush dropped valid", bus.if_valid, 1'b0);
        check("flush rdata unchanged", bus.if_rdata, 32'hFFFF_FFFF);
        step();
        check("redirect mem_req", bus.mem_req, 1'b1);
        check("redirect mem_addr", bus.mem_addr, 32'h80);
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'h0800_0080;
        step();
        bus.mem_ready = 1'b0; bus.mem_rdata = '0;
        check("redirect if_valid", bus.if_valid, 1'b1);
        check("redirect if_rdata", bus.if_rdata, 32'h0800_0080);
        bus.if_req = 1'b0;
        step();

        // Timeout: memory never answers a load
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h500;
        step();
        check("timeout mem_req", bus.mem_req, 1'b1);
        repeat (7) step();
        check("timeout 8th busy bus_err", bus.bus_err, 1'b0);
        check("timeout 8th busy mem_req", bus.mem_req, 1'b1);
        step();
        check("timeout bus_err", bus.bus_err, 1'b1);
        check("timeout mem_req dropped", bus.mem_req, 1'b0);
        check("timeout d_valid", bus.d_valid, 1'b1);
        check("timeout d_rdata", bus.d_rdata, 32'h0);
        bus.d_req = 1'b0;
        step();
        check("timeout d_valid one cycle", bus.d_valid, 1'b0);
        check("bus_err sticky", bus.bus_err, 1'b1);

        // Reset in the middle of a store
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_be = 4'hF; bus.d_addr = 32'h600; bus.d_wdata = 32'h1111_1111;
        step();
        check("rst pre mem_req", bus.mem_req, 1'b1);
        rst = 1'b1;
        step();
        check("rst mem_req", bus.mem_req, 1'b0);
        check("rst bus_err", bus.bus_err, 1'b0);
        check("rst d_valid", bus.d_valid, 1'b0);
        check("rst if_valid", bus.if_valid, 1'b0);
        rst = 1'b0; bus.d_req = 1'b0; bus.d_we = 1'b0;
        step();

        // Contention right after reset: data first, fetch launched with no bubble
        bus.if_req = 1'b1; bus.if_addr = 32'h300;
        bus.d_req = 1'b1; bus.d_addr = 32'h400;
        step();
        check("contend first grant addr", bus.mem_addr, 32'h400);
        check("contend first mem_req", bus.mem_req, 1'b1);
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'h5555_0000;
        step();
        check("contend no bubble mem_req", bus.mem_req, 1'b1);
        check("contend second grant addr", bus.mem_addr, 32'h300);
        check("contend d_valid", bus.d_valid, 1'b1);
        check("contend d_rdata", bus.d_rdata, 32'h5555_0000);
        check("contend if_stall", bus.if_stall, 1'b1);
        bus.d_req = 1'b0;
        bus.mem_rdata = 32'h6666_0000;
        step();
        bus.mem_ready = 1'b0; bus.mem_rdata = '0;
        check("contend if_valid", bus.if_valid, 1'b1);
        check("contend if_rdata", bus.if_rdata, 32'h6666_0000);
        check("contend idle mem_req", bus.mem_req, 1'b0);
        bus.if_req = 1'b0;
        step();
        check("contend no regrant", bus.mem_req, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
